i8254_bus_ctrl: RTL

- CPU-facing bus interface and control-word register file for the three-counter 8254 timer.
- Decodes CS/RD/WR/A1:A0 strobes and stores each counter's 6-bit control word.
- Sequences LSB/MSB count writes into byte strobes for the downstream counter blocks.
- Latches and serialises counter values for CPU reads; sits directly upstream of each counter instance.

---
 rtl/i8254_pkg.sv | 48 ++++
 rtl/i8254_bus_ctrl_if.sv | 28 ++
 rtl/i8254_cnt_port.sv | 102 ++++++++++
 rtl/i8254_bus_ctrl.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/i8254_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : i8254_pkg
//  Description : Shared encodings for the 8254 bus controller: read/write
//                mode (RW) codes, control-register address, control-word
//                field positions and the stored control-word type.
//  Revision    : 1.0  initial release
// ============================================================================
package i8254_pkg;

    // RW field of a control word; RW_LATCH doubles as the counter-latch command
    typedef enum logic [1:0] {
        RW_LATCH = 2'd0,
        RW_LSB   = 2'd1,
        RW_MSB   = 2'd2,
        RW_LM    = 2'd3
    } rw_e;

    localparam logic [1:0] ADDR_CTRL = 2'd3;

    // Field positions inside the stored 6-bit control word
    localparam int CW_BCD_BIT = 0;
    localparam int CW_MODE_LO = 1;
    localparam int CW_MODE_HI = 3;
    localparam int CW_RW_LO   = 4;
    localparam int CW_RW_HI   = 5;

    // Field positions inside a CPU control-register write byte
    localparam int CMD_SC_LO      = 6;
    localparam int CMD_SC_HI      = 7;
    localparam int RB_COUNT_N_BIT = 5;

    typedef logic [5:0] ctrl_word_t;

    function automatic rw_e cw_rw(input ctrl_word_t cw);
        return rw_e'(cw[CW_RW_HI:CW_RW_LO]);
    endfunction

    function automatic logic [2:0] cw_mode(input ctrl_word_t cw);
        return cw[CW_MODE_HI:CW_MODE_LO];
    endfunction

    function automatic logic cw_bcd(input ctrl_word_t cw);
        return cw[CW_BCD_BIT];
    endfunction

endpackage
`default_nettype wire

// File: rtl/i8254_bus_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : i8254_bus_ctrl_if
//  Description : CPU-side bus of the 8254 (chip select, strobes, address,
//                write data, registered read data and its drive enable).
//                master = CPU side, slave = i8254_bus_ctrl.
//  Revision    : 1.0  initial release
// ============================================================================
interface i8254_bus_ctrl_if;
    logic       cs_n;
    logic       rd_n;
    logic       wr_n;
    logic [1:0] addr;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       data_oe;

    modport master (
        output cs_n, rd_n, wr_n, addr, data_in,
        input  data_out, data_oe
    );

    modport slave (
        input  cs_n, rd_n, wr_n, addr, data_in,
        output data_out, data_oe
    );
endinterface
`default_nettype wire

// File: rtl/i8254_cnt_port.sv
`default_nettype none
// ============================================================================
//  Module      : i8254_cnt_port
//  Description : Per-counter bus state: stored control word, LSB/MSB write
//                and read flip-flops, output latch and read byte select.
//  Ports       : clk, rst_n        clock / synchronous active-low reset
//                cw_wr, cw_in      control-word rewrite request and value
//                latch_req         latch count_val unless already latched
//                cnt_wr            count byte committed to this counter
//                rd_done           a read of this counter completed
//                count_val         live counter value
//                ctrl_word         stored control word
//                ctrl_wr, count_wr_en, count_load  one-cycle pulses
//                rd_byte           byte presented for the next CPU read
//  Revision    : 1.0  initial release
// ============================================================================
module i8254_cnt_port
    import i8254_pkg::*;
(
    input  wire logic        clk,
    input  wire logic        rst_n,
    input  wire logic        cw_wr,
    input  wire ctrl_word_t  cw_in,
    input  wire logic        latch_req,
    input  wire logic        cnt_wr,
    input  wire logic        rd_done,
    input  wire logic [15:0] count_val,
    output ctrl_word_t       ctrl_word,
    output logic             ctrl_wr,
    output logic             count_wr_en,
    output logic             count_load,
    output logic [7:0]       rd_byte
);

    logic        r_wr_ff;
    logic        r_rd_ff;
    logic        r_latched;
    logic [15:0] r_latch;
    rw_e         w_rw;
    logic [15:0] w_src;

    assign w_rw    = cw_rw(ctrl_word);
    assign w_src   = r_latched ? r_latch : count_val;
    assign rd_byte = ((w_rw == RW_MSB) || ((w_rw == RW_LM) && r_rd_ff)) ? w_src[15:8]
                                                                      : w_src[7:0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ctrl_word   <= '0;
            ctrl_wr     <= 1'b0;
            count_wr_en <= 1'b0;
            count_load  <= 1'b0;
            r_wr_ff     <= 1'b0;
            r_rd_ff     <= 1'b0;
            r_latched   <= 1'b0;
            r_latch     <= '0;
        end else begin
            ctrl_wr     <= 1'b0;
            count_wr_en <= 1'b0;
            count_load  <= 1'b0;

            // A new control word restarts both byte sequences and drops any latch
            if (cw_wr) begin
                ctrl_word <= cw_in;
                ctrl_wr   <= 1'b1;
                r_wr_ff   <= 1'b0;
                r_rd_ff   <= 1'b0;
                r_latched <= 1'b0;
            end else if (latch_req && !r_latched) begin
                r_latch   <= count_val;
                r_latched <= 1'b1;
            end

            if (cnt_wr) begin
                case (w_rw)
                    RW_LSB, RW_MSB: begin
                        count_wr_en <= 1'b1;
                        count_load  <= 1'b1;
                    end
                    RW_LM: begin
                        count_wr_en <= 1'b1;
                        count_load  <= r_wr_ff;
                        r_wr_ff     <= ~r_wr_ff;
                    end
                    default: ;
                endcase
            end

            // Latch is released once the last byte of the value has been read
            if (rd_done) begin
                if (w_rw == RW_LM) begin
                    r_rd_ff <= ~r_rd_ff;
                end
                if ((w_rw != RW_LM) || r_rd_ff) begin
                    r_latched <= 1'b0;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/i8254_bus_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : i8254_bus_ctrl
//  Description : CPU bus interface and control-word register file for a
//                three-counter 8254. Strobes are registered once (S1); a
//                strobe rising edge is detected against S1, staged for one
//                cycle and then applied, so pulses appear two cycles after
//                the strobe rise.
//  Ports       : clk, rst_n   clock / synchronous active-low reset
//                bus          CPU bus (slave modport)
//                ctrl_word    {cw2,cw1,cw0}
//                ctrl_wr, count_wr_en, count_load  one-hot pulses
//                count_byte   shared count byte
//                count_val    {cnt2,cnt1,cnt0} live counter values
//  Config      : I8254_READBACK_EN enables the SC=3 read-back command
//                (count latch only); undefined, SC=3 writes are ignored.
//  Revision    : 1.0  initial release
// ============================================================================
module i8254_bus_ctrl
    import i8254_pkg::*;
#(
    parameter int NUM_CNT = 3,
    parameter int CW_W    = 6
) (
    input  wire logic                    clk,
    input  wire logic                    rst_n,
    i8254_bus_ctrl_if.slave              bus,
    output logic [NUM_CNT*CW_W-1:0]      ctrl_word,
    output logic [NUM_CNT-1:0]           ctrl_wr,
    output logic [7:0]                   count_byte,
    output logic [NUM_CNT-1:0]           count_wr_en,
    output logic [NUM_CNT-1:0]           count_load,
    input  wire logic [NUM_CNT*16-1:0]   count_val
);

    // S1 input stage
    logic       r_s1_cs_n, r_s1_rd_n, r_s1_wr_n;
    logic [1:0] r_s1_addr;
    logic [7:0] r_s1_data;

    // Staged bus events
    logic       r_ev_wr, r_ev_rd;
    logic [1:0] r_ev_addr;
    logic [7:0] r_ev_data;

    logic w_wr_commit, w_rd_commit, w_rd_active;

    logic [NUM_CNT-1:0] w_cw_wr, w_latch, w_rb, w_cnt_wr, w_cnt_acc, w_rd_done;
    ctrl_word_t         w_cw      [NUM_CNT];
    logic [7:0]         w_rd_byte [NUM_CNT];
    logic [7:0]         w_sel_byte;

    // Simultaneous rd/wr: the write wins and the read neither drives nor advances
    assign w_wr_commit = !r_s1_cs_n && !r_s1_wr_n && bus.wr_n;
    assign w_rd_commit = !r_s1_cs_n && !r_s1_rd_n && bus.rd_n && r_s1_wr_n
                         && (r_s1_addr != ADDR_CTRL);
    assign w_rd_active = !r_s1_cs_n && !r_s1_rd_n && r_s1_wr_n
                         && (r_s1_addr != ADDR_CTRL);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_cs_n <= 1'b1;
            r_s1_rd_n <= 1'b1;
            r_s1_wr_n <= 1'b1;
            r_s1_addr <= '0;
            r_s1_data <= '0;
            r_ev_wr   <= 1'b0;
            r_ev_rd   <= 1'b0;
            r_ev_addr <= '0;
            r_ev_data <= '0;
        end else begin
            r_s1_cs_n <= bus.cs_n;
            r_s1_rd_n <= bus.rd_n;
            r_s1_wr_n <= bus.wr_n;
            r_s1_addr <= bus.addr;
            r_s1_data <= bus.data_in;
            r_ev_wr   <= w_wr_commit;
            r_ev_rd   <= w_rd_commit;
            r_ev_addr <= r_s1_addr;
            r_ev_data <= r_s1_data;
        end
    end

    for (genvar i = 0; i < NUM_CNT; i++) begin : g_port
        logic w_hit_ctrl;

        assign w_hit_ctrl   = r_ev_wr && (r_ev_addr == ADDR_CTRL)
                              && (r_ev_data[CMD_SC_HI:CMD_SC_LO] == 2'(i));
        assign w_cw_wr[i]   = w_hit_ctrl && (r_ev_data[CW_RW_HI:CW_RW_LO] != RW_LATCH);
        assign w_latch[i]   = (w_hit_ctrl && (r_ev_data[CW_RW_HI:CW_RW_LO] == RW_LATCH))
                              || w_rb[i];
        assign w_cnt_wr[i]  = r_ev_wr && (r_ev_addr == 2'(i));
        assign w_cnt_acc[i] = w_cnt_wr[i] && (cw_rw(w_cw[i]) != RW_LATCH);
        assign w_rd_done[i] = r_ev_rd && (r_ev_addr == 2'(i));

`ifdef I8254_READBACK_EN
        // Read-back: bits [3:1] select counters 2..0, COUNT# low requests a latch
        assign w_rb[i] = r_ev_wr && (r_ev_addr == ADDR_CTRL)
                         && (r_ev_data[CMD_SC_HI:CMD_SC_LO] == 2'd3)
                         && !r_ev_data[RB_COUNT_N_BIT] && r_ev_data[1+i];
`else
        assign w_rb[i] = 1'b0;
`endif

        i8254_cnt_port u_port (
            .clk         (clk),
            .rst_n       (rst_n),
            .cw_wr       (w_cw_wr[i]),
            .cw_in       (r_ev_data[CW_W-1:0]),
            .latch_req   (w_latch[i]),
            .cnt_wr      (w_cnt_wr[i]),
            .rd_done     (w_rd_done[i]),
            .count_val   (count_val[i*16 +: 16]),
            .ctrl_word   (w_cw[i]),
            .ctrl_wr     (ctrl_wr[i]),
            .count_wr_en (count_wr_en[i]),
            .count_load  (count_load[i]),
            .rd_byte     (w_rd_byte[i])
        );

        assign ctrl_word[i*CW_W +: CW_W] = w_cw[i];
    end

    always_comb begin
        w_sel_byte = 8'h00;
        for (int k = 0; k < NUM_CNT; k++) begin
            if (r_s1_addr == 2'(k)) begin
                w_sel_byte = w_rd_byte[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_byte   <= '0;
            bus.data_out <= '0;
            bus.data_oe  <= 1'b0;
        end else begin
            if (|w_cnt_acc) begin
                count_byte <= r_ev_data;
            end
            bus.data_oe  <= w_rd_active;
            bus.data_out <= w_rd_active ? w_sel_byte : 8'h00;
        end
    end

endmodule
`default_nettype wire
